// File: rtl/press_timer_pkg.sv
// press_timer_pkg: shared types and constants for the press_timer slice.
//   state_e          FSM state encoding (IDLE, CHARGE, HOLD, LOCK)
//   PRESS_TIME_MAX   saturation value of press_time
//   DEF_*            default values for the press_timer / key_debouncer parameters
//   sat_inc()        saturating increment of a press_time value
package press_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHARGE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_LOCK   = 2'd3
  } state_e;

  localparam logic [3:0] PRESS_TIME_MAX = 4'd15;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_TICKS_PER_STEP  = 4;
  localparam int DEF_HOLD_TIMEOUT    = 2;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == PRESS_TIME_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/press_timer_if.sv
// press_timer_if: button/display-side signal bundle of press_timer.
//   key_in        raw jump button (asynchronous), 1 = pressed
//   frame_tick    one-cycle strobe at the frame/animation rate
//   flight_busy   display stage is animating a jump
//   is_pressing   a charge is in progress
//   press_time    charge amount (4 bits)
//   release_pulse one-cycle strobe on the cycle CHARGE exits
// master: the environment driving the button/display; slave: press_timer.
interface press_timer_if;
  logic       key_in;
  logic       frame_tick;
  logic       flight_busy;
  logic       is_pressing;
  logic [3:0] press_time;
  logic       release_pulse;

  modport master (
    output key_in, frame_tick, flight_busy,
    input  is_pressing, press_time, release_pulse
  );

  modport slave (
    input  key_in, frame_tick, flight_busy,
    output is_pressing, press_time, release_pulse
  );
endinterface

// File: rtl/press_timer_key_debouncer.sv
// key_debouncer: accepts a new level on din only after DEBOUNCE_CYCLES
// consecutive samples that differ from the current output.
//   clk    system clock
//   rst_n  asynchronous active-low reset (output and counter clear to 0)
//   din    synchronised input level
//   dout   debounced level
module key_debouncer
  import press_timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          dout_q, dout_d;

  // A matching sample restarts the run; the Nth mismatch flips the output.
  always_comb begin
    cnt_d  = '0;
    dout_d = dout_q;
    if (din != dout_q) begin
      if (cnt_q == CNT_LAST) begin
        dout_d = din;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/press_timer.sv
// press_timer: jump-button charge timer. Measures how long the key is held
// in units of TICKS_PER_STEP frame ticks, freezes the result on release and
// locks out new charges until the display has finished the jump.
//   clk          system clock (rising edge)
//   rst_n        asynchronous active-low reset
//   bus          press_timer_if.slave (key_in, frame_tick, flight_busy in;
//                is_pressing, press_time, release_pulse out)
// Optional build macro PRESS_TIMER_DEBOUNCE_EN: inserts key_debouncer after
// the synchroniser; otherwise the synchronised key is used directly.
//
// state  | meaning
// IDLE   | waiting for a fresh key press; press_time held at 0
// CHARGE | key held; press_time grows every TICKS_PER_STEP frame ticks
// HOLD   | key released; waiting for flight_busy or a frame-tick timeout
// LOCK   | jump animating; waiting for flight_busy to fall
module press_timer
  import press_timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TICKS_PER_STEP  = DEF_TICKS_PER_STEP,
  parameter int HOLD_TIMEOUT    = DEF_HOLD_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst_n,
  press_timer_if.slave    bus
);

  localparam int SW = $clog2(TICKS_PER_STEP);
  localparam int HW = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(TICKS_PER_STEP - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TIMEOUT - 1);

  if (DEBOUNCE_CYCLES < 1 || TICKS_PER_STEP < 2 || HOLD_TIMEOUT < 1) begin : g_bad_params
    $error("press_timer: unsupported parameter values");
  end

  logic [1:0]    sync_q;
  logic          key_sync, key_stable;
  logic          key_prev_q, busy_prev_q;
  logic [1:0]    prime_q;
  logic          armed_q;
  state_e        state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    press_q, press_d;
  logic          release_d;
  logic          key_rise, key_fall, busy_fall;

  assign key_sync = sync_q[1];

`ifdef PRESS_TIMER_DEBOUNCE_EN
  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (key_sync),
    .dout  (key_stable)
  );
`else
  assign key_stable = key_sync;
`endif

  assign key_rise  = key_stable & ~key_prev_q;
  assign key_fall  = ~key_stable & key_prev_q;
  assign busy_fall = ~bus.flight_busy & busy_prev_q;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    hold_d    = hold_q;
    press_d   = press_q;
    release_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        press_d = '0;
        step_d  = '0;
        hold_d  = '0;
        if (key_rise && armed_q && !bus.flight_busy) begin
          state_d = ST_CHARGE;
        end
      end
      ST_CHARGE: begin
        // Release has priority over a coincident frame tick.
        if (key_fall) begin
          state_d   = ST_HOLD;
          release_d = 1'b1;
          step_d    = '0;
          hold_d    = HOLD_LOAD;
        end else if (bus.frame_tick) begin
          if (step_q == STEP_LAST) begin
            step_d  = '0;
            press_d = sat_inc(press_q);
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (bus.flight_busy) begin
          state_d = ST_LOCK;
        end else if (bus.frame_tick) begin
          if (hold_q == '0) begin
            state_d = ST_IDLE;
            press_d = '0;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
      end
      ST_LOCK: begin
        if (busy_fall) begin
          state_d = ST_IDLE;
          press_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        press_d = '0;
      end
    endcase
  end

  // prime_q marks when key_sync carries a real post-reset sample; the key
  // must be seen released after that before any charge may start, so a key
  // held through reset cannot trigger a charge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      key_prev_q  <= 1'b0;
      busy_prev_q <= 1'b0;
      prime_q     <= '0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      step_q      <= '0;
      hold_q      <= '0;
      press_q     <= '0;
    end else begin
      sync_q      <= {sync_q[0], bus.key_in};
      key_prev_q  <= key_stable;
      busy_prev_q <= bus.flight_busy;
      prime_q     <= {prime_q[0], 1'b1};
      armed_q     <= armed_q | (prime_q[1] & ~key_sync);
      state_q     <= state_d;
      step_q      <= step_d;
      hold_q      <= hold_d;
      press_q     <= press_d;
    end
  end

  assign bus.is_pressing   = (state_q == ST_CHARGE);
  assign bus.press_time    = press_q;
  assign bus.release_pulse = release_d;

endmodule

// File: doc/press_timer.md
PRESS_TIMER -- requirements
Module: press_timer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive equal synchronised samples required before the key level is accepted.
REQ-002 Parameter TICKS_PER_STEP, default 4: number of frame_tick strobes per press_time increment.
REQ-003 Parameter HOLD_TIMEOUT, default 2: number of frame_tick strobes to wait in HOLD for flight_busy before returning to IDLE.
REQ-004 clk  in  1  single system clock; all logic is clocked on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 key_in  in  1  raw jump button, asynchronous to clk; 1 means pressed.
REQ-007 frame_tick  in  1  one-cycle strobe at the display frame/animation rate.
REQ-008 flight_busy  in  1  high while the display stage is animating a jump.
REQ-009 is_pressing  out  1  high while a charge is in progress.
REQ-010 press_time  out  4  charge amount; it grows while charging and is frozen after release.
REQ-011 release_pulse  out  1  one-cycle strobe on the cycle that CHARGE exits.

Function
REQ-012 key_in SHALL pass through a two-flop synchroniser; key_sync lags key_in by 2 cycles.
REQ-013 key_stable SHALL change only after DEBOUNCE_CYCLES consecutive cycles where key_sync differs from the current key_stable; any mismatch-free sample resets the count.
REQ-014 The FSM SHALL have states IDLE, CHARGE, HOLD and LOCK.
REQ-015 IDLE: is_pressing=0 and press_time=0; a key_stable rising edge with flight_busy=0 SHALL move to CHARGE on the next cycle, with step_cnt=0.
REQ-016 IDLE SHALL ignore a key_stable that is already high on entry; only a rising edge starts a charge.
REQ-017 CHARGE: is_pressing=1; each frame_tick increments step_cnt; when step_cnt==TICKS_PER_STEP-1 on a frame_tick, step_cnt SHALL clear and press_time SHALL increment.
REQ-018 press_time SHALL saturate at 15 and never wrap.
REQ-019 CHARGE: a key_stable falling edge SHALL move to HOLD, assert release_pulse for exactly that cycle, drop is_pressing on the next cycle, and freeze press_time.
REQ-020 If a key_stable falling edge and a frame_tick occur in the same cycle, the release SHALL win and press_time SHALL NOT increment.
REQ-021 HOLD: flight_busy=1 SHALL move to LOCK; after HOLD_TIMEOUT frame_ticks with flight_busy=0, the FSM SHALL move to IDLE.
REQ-022 LOCK: a flight_busy falling edge SHALL move to IDLE; key activity in HOLD and LOCK SHALL be ignored.
REQ-023 press_time SHALL stay frozen in HOLD and LOCK and clear on entry to IDLE.
REQ-024 Counter widths: step_cnt uses $clog2(TICKS_PER_STEP) bits; the debounce counter uses $clog2(DEBOUNCE_CYCLES+1) bits.

Reset
REQ-025 Asserting rst_n low SHALL, at any time including mid-charge, force the IDLE state, is_pressing=0, press_time=0, release_pulse=0, all counters to 0, and the synchroniser and key_stable to 0.
REQ-026 After rst_n deasserts, a key already held SHALL NOT start a charge until it has been released and pressed again.

Configuration
REQ-027 With PRESS_TIMER_DEBOUNCE_EN defined, the debouncer of REQ-013 SHALL be instantiated.
REQ-028 Without PRESS_TIMER_DEBOUNCE_EN, key_stable SHALL equal key_sync (2-cycle latency) and DEBOUNCE_CYCLES SHALL be unused.

Structure
REQ-029 Package press_timer_pkg SHALL hold the FSM state enum, PRESS_TIME_MAX=15 and the default parameter constants.
REQ-030 The debounce logic SHALL be the sub-module key_debouncer (ports clk, rst_n, din, dout).

Verification
REQ-031 Reset: pulse rst_n low for 3 cycles during CHARGE with press_time=7 -> next cycle press_time=0, is_pressing=0, state IDLE.
REQ-032 Charge: hold key for 24 frame_ticks (TICKS_PER_STEP=4), then release -> press_time=6, release_pulse for exactly 1 cycle, is_pressing low 1 cycle later.
REQ-033 Saturation: hold key for 80 frame_ticks -> press_time reaches 15 at tick 60 and stays 15.
REQ-034 Bounce: toggle key every 5 cycles for 100 cycles with the macro defined -> no CHARGE entry; same stimulus without the macro -> CHARGE entered.
REQ-035 Lockout: release, raise flight_busy 1 tick later, press the key during LOCK, then drop flight_busy -> IDLE with press_time=0 and no new charge until a fresh press edge.
REQ-036 Tie and timeout: release on the same cycle as the 4th frame_tick -> press_time unchanged; with flight_busy never asserted -> IDLE after 2 frame_ticks.
